// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-word output buffer.
// The shift register keeps collecting bits while the output word waits for the consumer.
//
// Parameters:
//   n          parallel word width in bits (n >= 2)
//   MSB_FIRST  1: the first received bit lands in b[n-1]; 0: it lands in b[0]
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   sin        serial data bit, sampled only when sin_valid=1
//   sin_valid  qualifies sin
//   b          deserialized word
//   b_valid    b holds an unconsumed word
//   b_ready    consumer takes b on an edge with b_valid=1 and b_ready=1
//   busy       a partial frame is being collected
//   overrun    sticky: a completed word was dropped (cleared only by rst)
//   parity_err one-cycle pulse on a bad parity bit (always 0 without parity)
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every frame.
module sipo_deser #(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [n-1:0] b,
  output logic         b_valid,
  input  logic         b_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);
`ifdef SIPO_PARITY_EN
  localparam logic [CW-1:0] FULL = CW'(n);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    sh_q, sh_d;
  logic [n-1:0]    b_q, b_d;
  logic            bv_q, bv_d;
  logic            ov_q, ov_d;
`ifdef SIPO_PARITY_EN
  logic            pe_q, pe_d;
  logic            perr;
`endif

  logic [n-1:0]    sh_in;
  logic [n-1:0]    word;
  logic            done;

  // Shift direction decides where the first bit ends up after n shifts.
  always_comb begin
    if (MSB_FIRST) sh_in = {sh_q[n-2:0], sin};
    else           sh_in = {sin, sh_q[n-1:1]};
  end

  // Frame collection: state, count, shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    word    = sh_q;
    done    = 1'b0;
`ifdef SIPO_PARITY_EN
    perr    = 1'b0;
`endif
    if (sin_valid) begin
      unique case (state_q)
        IDLE, SHIFT: begin
          sh_d = sh_in;
          if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
            // Data complete; hold the word and wait for parity.
            cnt_d   = FULL;
            state_d = PAR;
`else
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
            word    = sh_in;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
          end
        end
`ifdef SIPO_PARITY_EN
        PAR: begin
          cnt_d   = '0;
          state_d = IDLE;
          done    = 1'b1;
          word    = sh_q;
          // Even parity: data plus parity bit must XOR to 0.
          perr    = ^{sh_q, sin};
        end
`endif
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output buffer: load on completion if free or being drained,
  // otherwise drop the new word and flag overrun.
  always_comb begin
    b_d  = b_q;
    bv_d = bv_q;
    ov_d = ov_q;
`ifdef SIPO_PARITY_EN
    pe_d = perr;
`endif
    if (done) begin
      if (!bv_q || b_ready) begin
        b_d  = word;
        bv_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (bv_q && b_ready) begin
      bv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      bv_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      bv_q    <= bv_d;
      ov_q    <= ov_d;
`ifdef SIPO_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  assign b       = b_q;
  assign b_valid = bv_q;
  assign overrun = ov_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = pe_q;
  assign busy       = (cnt_q != '0) || (state_q == PAR);
`else
  assign parity_err = 1'b0;
  assign busy       = (cnt_q != '0);
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: randomized and directed checks of sipo_deser (n=5),
// one instance per bit order, against a queue-based frame model.
module tb_sipo_deser;

  localparam int N = 5;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic clk = 1'b0;
  logic rst, sin, sin_valid, b_ready;
  // index 0: MSB_FIRST=0, index 1: MSB_FIRST=1
  logic [N-1:0] db [2];
  logic dbv [2];
  logic dbusy [2];
  logic dov [2];
  logic dpe [2];

  int tests = 0;
  int fails = 0;

  // Model state
  logic mbits [$];
  logic [N-1:0] mb [2];
  logic mbv [2];
  logic mov [2];
  logic mpe;

  always #5 clk = ~clk;

  sipo_deser #(.n(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .b(db[0]), .b_valid(dbv[0]), .b_ready(b_ready),
    .busy(dbusy[0]), .overrun(dov[0]), .parity_err(dpe[0])
  );

  sipo_deser #(.n(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .b(db[1]), .b_valid(dbv[1]), .b_ready(b_ready),
    .busy(dbusy[1]), .overrun(dov[1]), .parity_err(dpe[1])
  );

  // Drive one cycle, advance the model across the edge, return #1 after it.
  task automatic step(input logic s, input logic v,
                      input logic r, input logic rs);
    logic [N-1:0] w [2];
    logic done;
    @(negedge clk);
    sin = s; sin_valid = v; b_ready = r; rst = rs;
    @(posedge clk);
    done = 1'b0;
    if (rs) begin
      mbits.delete();
      mpe = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mb[k] = '0; mbv[k] = 1'b0; mov[k] = 1'b0;
      end
    end else begin
      mpe = 1'b0;
      if (v) begin
        mbits.push_back(s);
        if (mbits.size() == FRAME) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) begin
            w[1][N-1-i] = mbits[i];
            w[0][i]     = mbits[i];
          end
          if (FRAME > N)
            for (int i = 0; i < FRAME; i++) mpe ^= mbits[i];
          mbits.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (done) begin
          if (!mbv[k] || r) begin
            mb[k] = w[k]; mbv[k] = 1'b1;
          end else begin
            mov[k] = 1'b1;
          end
        end else if (mbv[k] && r) begin
          mbv[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  // Send one frame, first bit = f[N-1]; b_ready is r_last only on the final bit.
  task automatic send_frame(input logic [N-1:0] f, input logic r_last,
                            input logic gaps, input logic bad_par);
    logic bv;
    for (int i = 0; i < FRAME; i++) begin
      if (i < N) bv = f[N-1-i];
      else       bv = (^f) ^ bad_par;
      if (gaps)
        repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      step(bv, 1'b1, (i == FRAME - 1) ? r_last : 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (db[k] !== '0) begin
        fails++; $display("FAIL reset_b[%0d] got %b exp 0", k, db[k]);
      end
      tests++;
      if (dbv[k] !== 1'b0 || dov[k] !== 1'b0) begin
        fails++; $display("FAIL reset_flags[%0d] got bv=%b ov=%b exp 0,0", k, dbv[k], dov[k]);
      end
      tests++;
      if (dbusy[k] !== 1'b0 || dpe[k] !== 1'b0) begin
        fails++; $display("FAIL reset_busy_pe[%0d] got busy=%b pe=%b exp 0,0", k, dbusy[k], dpe[k]);
      end
    end
  endtask

  task automatic test_bit_order();
    logic [N-1:0] e1, e0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(5'b10101, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (db[k] !== 5'b10101 || dbv[k] !== 1'b1 || dbusy[k] !== 1'b0) begin
        fails++; $display("FAIL order_10101[%0d] got b=%b bv=%b busy=%b exp 10101,1,0",
                          k, db[k], dbv[k], dbusy[k]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (dbv[k] !== 1'b0 || db[k] !== 5'b10101) begin
        fails++; $display("FAIL consume[%0d] got b=%b bv=%b exp 10101,0", k, db[k], dbv[k]);
      end
    end
    send_frame(5'b00111, 1'b0, 1'b0, 1'b0);
    e1 = 5'b00111; e0 = 5'b11100;
    tests++;
    if (db[1] !== e1 || db[0] !== e0) begin
      fails++; $display("FAIL order_00111 got msb=%b lsb=%b exp %b,%b", db[1], db[0], e1, e0);
    end
  endtask

  task automatic test_overrun();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(5'b10101, 1'b0, 1'b0, 1'b0);
    send_frame(5'b00111, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (db[k] !== 5'b10101 || dbv[k] !== 1'b1 || dov[k] !== 1'b1) begin
        fails++; $display("FAIL overrun[%0d] got b=%b bv=%b ov=%b exp 10101,1,1",
                          k, db[k], dbv[k], dov[k]);
      end
    end
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (dov[k] !== 1'b1 || dbv[k] !== 1'b0) begin
        fails++; $display("FAIL overrun_sticky[%0d] got ov=%b bv=%b exp 1,0", k, dov[k], dbv[k]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (dov[0] !== 1'b0 || dov[1] !== 1'b0) begin
      fails++; $display("FAIL overrun_clear got %b%b exp 00", dov[1], dov[0]);
    end
  endtask

  task automatic test_back_to_back();
    int bubbles;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(5'b00111, 1'b0, 1'b0, 1'b0);
    // Word pending; second frame completes with b_ready=1 on that edge.
    bubbles = 0;
    for (int i = 0; i < FRAME; i++) begin
      step((i < N) ? 1'(5'b11000 >> (N-1-i)) : 1'(^5'b11000), 1'b1,
           (i == FRAME - 1), 1'b0);
      if (dbv[1] !== 1'b1) bubbles++;
    end
    tests++;
    if (bubbles != 0 || db[1] !== 5'b11000 || db[0] !== 5'b00011 || dov[1] !== 1'b0) begin
      fails++; $display("FAIL back_to_back got bubbles=%0d msb=%b lsb=%b ov=%b exp 0,11000,00011,0",
                        bubbles, db[1], db[0], dov[1]);
    end
    // Continuously ready consumer.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FRAME; i++) begin
        step((i < N) ? 1'(((f == 0) ? 5'b00111 : 5'b11000) >> (N-1-i))
                     : 1'(^((f == 0) ? 5'b00111 : 5'b11000)), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (dbv[k] !== mbv[k] || db[k] !== mb[k] || dov[k] !== 1'b0) begin
            fails++; $display("FAIL ready_stream[%0d] got b=%b bv=%b ov=%b exp %b,%b,0",
                              k, db[k], dbv[k], dov[k], mb[k], mbv[k]);
          end
        end
      end
    tests++;
    if (db[1] !== 5'b11000 || dbv[1] !== 1'b1) begin
      fails++; $display("FAIL ready_stream_end got b=%b bv=%b exp 11000,1", db[1], dbv[1]);
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (dbusy[0] !== 1'b1 || dbusy[1] !== 1'b1) begin
      fails++; $display("FAIL midframe_busy got %b%b exp 11", dbusy[1], dbusy[0]);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    tests++;
    if (dbusy[1] !== 1'b0 || dbv[1] !== 1'b0) begin
      fails++; $display("FAIL midframe_rst got busy=%b bv=%b exp 0,0", dbusy[1], dbv[1]);
    end
    send_frame(5'b01010, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (db[k] !== 5'b01010 || dbv[k] !== 1'b1) begin
        fails++; $display("FAIL midframe_word[%0d] got b=%b bv=%b exp 01010,1", k, db[k], dbv[k]);
      end
    end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(5'b10101, 1'b1, 1'b0, 1'b1);
    tests++;
    if (dpe[1] !== 1'b1 || db[1] !== 5'b10101 || dbv[1] !== 1'b1) begin
      fails++; $display("FAIL parity_bad got pe=%b b=%b bv=%b exp 1,10101,1", dpe[1], db[1], dbv[1]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (dpe[1] !== 1'b0) begin
      fails++; $display("FAIL parity_pulse got pe=%b exp 0", dpe[1]);
    end
    send_frame(5'b10101, 1'b1, 1'b0, 1'b0);
    tests++;
    if (dpe[1] !== 1'b0 || db[1] !== 5'b10101 || dbv[1] !== 1'b1) begin
      fails++; $display("FAIL parity_good got pe=%b b=%b bv=%b exp 0,10101,1", dpe[1], db[1], dbv[1]);
    end
  endtask
`endif

  task automatic test_random();
    logic s, v, r, rs;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      s  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 59) == 0);
      step(s, v, r, rs);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (db[k] !== mb[k] || dbv[k] !== mbv[k] || dov[k] !== mov[k] ||
            dbusy[k] !== (mbits.size() != 0) || dpe[k] !== mpe) begin
          fails++;
          $display("FAIL random[%0d] cyc %0d got b=%b bv=%b ov=%b busy=%b pe=%b exp %b,%b,%b,%b,%b",
                   k, c, db[k], dbv[k], dov[k], dbusy[k], dpe[k],
                   mb[k], mbv[k], mov[k], (mbits.size() != 0), mpe);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; b_ready = 1'b0;
    mpe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mb[k] = '0; mbv[k] = 1'b0; mov[k] = 1'b0;
    end
    test_reset();
    test_bit_order();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
